// File: rtl/tb_run_ctrl_pkg.sv
// Shared types and helpers for the test-bench run controller.
// Holds the run-state encoding and a counter sizing helper.
package tb_run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RST_HOLD  = 3'd1,
        RUN       = 3'd2,
        DRAIN     = 3'd3,
        FINISHED  = 3'd4,
        TIMED_OUT = 3'd5
    } run_state_e;

    // Number of bits needed to represent value (at least 1).
    function automatic int unsigned bits_for(input longint unsigned value);
        int unsigned n;
        n = 32'd1;
        for (int unsigned i = 0; i < 64; i++) begin
            if (value[i]) begin
                n = i + 32'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/tb_run_ctrl_wdog.sv
// One watchdog channel: counts enabled cycles, restarts on kick or clear,
// and flags expiry after TIMEOUT_CYCLES consecutive un-kicked enabled cycles.
module tb_wdog_ch
    import tb_run_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic kick,
    output logic expire
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

    if (CNT_W < bits_for(longint'(TIMEOUT_CYCLES))) begin : g_bad_cnt_w
        $error("tb_wdog_ch: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    logic [CNT_W-1:0] cnt_r;

    // Channel counter; holds at the last value so it can never wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en && kick) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en && (cnt_r != CNT_LAST)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // A kick in the expiry cycle wins over the expiry.
    assign expire = en & ~kick & (cnt_r == CNT_LAST);

endmodule

// File: rtl/tb_run_ctrl.sv
// Run controller for register-block test benches: sequences DUT reset,
// runs NUM_CH watchdog channels and reports finish or the first expiry.
// Channel 0 is the global test timeout; its kick is normally tied low
// by the instantiating bench.
// Optional macro TB_RUN_CTRL_ELAPSED_EN adds the 'elapsed' cycle counter.
module tb_run_ctrl
    import tb_run_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned RST_CYCLES     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned FINISH_DELAY   = 5,
    parameter int unsigned CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] kick,
    input  logic              done,
    output logic              dut_rst,
    output logic              dut_rst_n,
    output logic              busy,
    output logic              timeout,
    output logic [NUM_CH-1:0] timeout_ch,
    output logic              finish,
    output logic [2:0]        state
`ifdef TB_RUN_CTRL_ELAPSED_EN
    ,
    output logic [CNT_W-1:0]  elapsed
`endif
);

    localparam int unsigned MAX_RT  = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_RT > FINISH_DELAY) ? MAX_RT : FINISH_DELAY;

    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((FINISH_DELAY > 32'd0) ? (FINISH_DELAY - 32'd1) : 32'd0);

    if (NUM_CH < 32'd1) begin : g_bad_num_ch
        $error("tb_run_ctrl: NUM_CH must be >= 1");
    end
    if (RST_CYCLES < 32'd1) begin : g_bad_rst_cycles
        $error("tb_run_ctrl: RST_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 32'd2) begin : g_bad_timeout
        $error("tb_run_ctrl: TIMEOUT_CYCLES must be >= 2");
    end
    if (CNT_W < bits_for(longint'(MAX_CNT))) begin : g_bad_cnt_w
        $error("tb_run_ctrl: CNT_W too narrow for the configured cycle counts");
    end

    run_state_e        state_r;
    run_state_e        state_nx_s;
    logic [CNT_W-1:0]  rst_cnt_r;
    logic [CNT_W-1:0]  drain_cnt_r;
    logic [NUM_CH-1:0] exp_s;
    logic              any_exp_s;
    logic              wd_en_s;
    logic              wd_clr_s;
    logic              restart_s;
    logic              dut_rst_r;
    logic              busy_r;
    logic              finish_r;
    logic              timeout_r;
    logic [NUM_CH-1:0] timeout_ch_r;

    // Watchdogs run only in RUN and DRAIN; outside they are held cleared,
    // which also clears them on RUN entry and makes kicks inert.
    assign wd_en_s   = (state_r == RUN) || (state_r == DRAIN);
    assign wd_clr_s  = ~wd_en_s;
    assign any_exp_s = |exp_s;
    assign restart_s = (state_nx_s == RST_HOLD) && (state_r != RST_HOLD);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        tb_wdog_ch #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (wd_en_s),
            .clr    (wd_clr_s),
            .kick   (kick[gi]),
            .expire (exp_s[gi])
        );
    end

    // Next-state decode; an expiry always beats done.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE, FINISHED, TIMED_OUT: begin
                if (start) begin
                    state_nx_s = RST_HOLD;
                end else begin
                    state_nx_s = state_r;
                end
            end
            RST_HOLD: begin
                if (rst_cnt_r == RST_LAST) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = RST_HOLD;
                end
            end
            RUN: begin
                if (any_exp_s) begin
                    state_nx_s = TIMED_OUT;
                end else if (done) begin
                    state_nx_s = (FINISH_DELAY == 32'd0) ? FINISHED : DRAIN;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DRAIN: begin
                if (any_exp_s) begin
                    state_nx_s = TIMED_OUT;
                end else if (drain_cnt_r == DRAIN_LAST) begin
                    state_nx_s = FINISHED;
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register plus the reset-hold and drain counters, which count
    // only while staying in their own state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            rst_cnt_r   <= {CNT_W{1'b0}};
            drain_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            if ((state_r == RST_HOLD) && (state_nx_s == RST_HOLD)) begin
                rst_cnt_r <= rst_cnt_r + CNT_W'(1);
            end else begin
                rst_cnt_r <= {CNT_W{1'b0}};
            end
            if ((state_r == DRAIN) && (state_nx_s == DRAIN)) begin
                drain_cnt_r <= drain_cnt_r + CNT_W'(1);
            end else begin
                drain_cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    // Sticky timeout status: captured on the expiry edge, cleared on restart.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timeout_r    <= 1'b0;
            timeout_ch_r <= {NUM_CH{1'b0}};
        end else if (restart_s) begin
            timeout_r    <= 1'b0;
            timeout_ch_r <= {NUM_CH{1'b0}};
        end else if ((state_nx_s == TIMED_OUT) && (state_r != TIMED_OUT)) begin
            timeout_r    <= 1'b1;
            timeout_ch_r <= exp_s;
        end else begin
            timeout_r    <= timeout_r;
            timeout_ch_r <= timeout_ch_r;
        end
    end

    // State-decoded outputs, registered from the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dut_rst_r <= 1'b1;
            busy_r    <= 1'b0;
            finish_r  <= 1'b0;
        end else begin
            dut_rst_r <= (state_nx_s == IDLE) || (state_nx_s == RST_HOLD);
            busy_r    <= (state_nx_s == RST_HOLD) || (state_nx_s == RUN) || (state_nx_s == DRAIN);
            finish_r  <= (state_nx_s == FINISHED);
        end
    end

    assign dut_rst    = dut_rst_r;
    assign dut_rst_n  = ~dut_rst_r;
    assign busy       = busy_r;
    assign finish     = finish_r;
    assign timeout    = timeout_r;
    assign timeout_ch = timeout_ch_r;
    assign state      = state_r;

`ifdef TB_RUN_CTRL_ELAPSED_EN
    logic [CNT_W-1:0] elapsed_r;

    // Saturating count of cycles spent in RUN and DRAIN; frozen in terminal states.
    always_ff @(posedge clk) begin
        if (!rst) begin
            elapsed_r <= {CNT_W{1'b0}};
        end else if (restart_s) begin
            elapsed_r <= {CNT_W{1'b0}};
        end else if (wd_en_s && (elapsed_r != {CNT_W{1'b1}})) begin
            elapsed_r <= elapsed_r + CNT_W'(1);
        end else begin
            elapsed_r <= elapsed_r;
        end
    end

    assign elapsed = elapsed_r;
`endif

endmodule
